// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: LW/SW handshake FSM (IDLE->REQ->WAIT->DONE) between the MEM stage and data memory.
// Optional MEM_ALIGN_CHECK_EN: odd addresses abort straight to DONE with err.
module mem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemEnable,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
    logic              misalign;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = addr[0];
`else
    assign misalign = 1'b0;
`endif
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: if (MemEnable) begin
                mem_addr_d  = addr;
                mem_wdata_d = wdata;
                wr_d        = MemWrite;
                state_d     = misalign ? DONE : REQ;
                done_d      = misalign;
                err_d       = misalign;
                mem_en_d    = !misalign;
                mem_wr_d    = !misalign && MemWrite;
            end
            REQ: begin
                state_d = WAIT;
                cnt_d   = 8'd0;
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // a response on the timeout cycle still counts as a normal completion
                if (mem_valid) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? rdata_q : mem_rdata;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end
    assign stall     = (state_q == IDLE && MemEnable) || state_q == REQ || state_q == WAIT;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed table, hand-written corner sequences and random transactions
// checked against a transaction-level model of mem_access_ctrl.
module tb_mem_access_ctrl;
    localparam int T = 8;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic        MemEnable = 1'b0, MemWrite = 1'b0, mem_valid = 1'b0;
    logic [15:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic        mem_en, mem_wr, stall, done, err;
    logic [15:0] mem_addr, mem_wdata, rdata;
    int          errors = 0, checks = 0;
    logic [15:0] m_rdata = '0;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .MemEnable(MemEnable), .MemWrite(MemWrite),
        .addr(addr), .wdata(wdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .rdata(rdata), .stall(stall), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [15:0] a, wd, rd;
        int          k;   // WAIT cycle carrying mem_valid; 0 = no response
        int          st;  // expected stall cycles == done offset
        logic        er;
        logic [15:0] xr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access; caller is positioned 1 time unit after a rising edge with the DUT idle.
    task automatic run_access(input logic we, input logic [15:0] a, input logic [15:0] wd,
                              input int k, input logic [15:0] rd, input int exp_st,
                              input logic exp_er, input logic [15:0] exp_rd, input bit mis);
        int n_en = 0, en_at = -1, n_stall = 0, n_done = 0, done_at = -1;
        logic wr_at = 1'b0, err1 = 1'b1, err_dn = 1'b0, seen = 1'b0;
        logic [15:0] ad = '0, wdd = '0;
        for (int c = 0; c < 16; c++) begin
            MemEnable = !seen;
            MemWrite  = (c == 0) ? we : 1'($urandom);
            addr      = (c == 0) ? a : 16'($urandom);
            wdata     = (c == 0) ? wd : 16'($urandom);
            mem_valid = (k != 0) && (c == k + 1);
            mem_rdata = (c == k + 1) ? rd : 16'($urandom);
            @(negedge clk);
            if (mem_en) begin
                n_en++;
                if (n_en == 1) begin en_at = c; wr_at = mem_wr; end
            end
            if (c == 1) err1 = err;
            if (stall) n_stall++;
            if (done) begin
                n_done++;
                if (!seen) begin done_at = c; err_dn = err; ad = mem_addr; wdd = mem_wdata; end
                seen = 1'b1;
            end
            next_cycle();
        end
        mem_valid = 1'b0;
        chk("mem_en_count", n_en, mis ? 0 : 1);
        if (!mis) begin
            chk("mem_en_offset", en_at, 1);
            chk("mem_wr", wr_at, we);
            chk("err_cleared_at_req", err1, 0);
            chk("mem_wdata", wdd, wd);
        end
        chk("stall_cycles", n_stall, exp_st);
        chk("done_offset", done_at, exp_st);
        chk("done_count", n_done, 1);
        chk("err", err_dn, exp_er);
        chk("mem_addr", ad, a);
        chk("rdata", rdata, exp_rd);
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{we: 1'b0, a: 16'h0010, wd: 16'h0000, rd: 16'hBEEF, k: 3, st: 5,  er: 1'b0, xr: 16'hBEEF};
        vt[1] = '{we: 1'b1, a: 16'h0020, wd: 16'h1234, rd: 16'h5555, k: 1, st: 3,  er: 1'b0, xr: 16'hBEEF};
        vt[2] = '{we: 1'b0, a: 16'h0030, wd: 16'h0000, rd: 16'h7777, k: 0, st: 10, er: 1'b1, xr: 16'hBEEF};
        vt[3] = '{we: 1'b0, a: 16'h0040, wd: 16'h0000, rd: 16'h4321, k: 8, st: 10, er: 1'b0, xr: 16'h4321};
`ifdef MEM_ALIGN_CHECK_EN
        vt[4] = '{we: 1'b0, a: 16'h0011, wd: 16'h0000, rd: 16'h0A0A, k: 2, st: 1,  er: 1'b1, xr: 16'h4321};
`else
        vt[4] = '{we: 1'b0, a: 16'h0011, wd: 16'h0000, rd: 16'h0A0A, k: 2, st: 4,  er: 1'b0, xr: 16'h0A0A};
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_stall", stall, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        next_cycle();

        foreach (vt[i])
            run_access(vt[i].we, vt[i].a, vt[i].wd, vt[i].k, vt[i].rd, vt[i].st, vt[i].er,
                       vt[i].xr, ALIGN && vt[i].a[0]);
        m_rdata = vt[4].xr;

        begin : back_to_back
            int n_en = 0;
            MemWrite = 1'b0;
            addr = 16'h0050;
            for (int c = 0; c < 10; c++) begin
                MemEnable = (c < 8);
                mem_valid = (c == 2) || (c == 6);
                mem_rdata = (c == 2) ? 16'h1111 : 16'h2222;
                @(negedge clk);
                if (mem_en) n_en++;
                if (c == 1 || c == 5) chk($sformatf("b2b_mem_en_c%0d", c), mem_en, 1);
                if (c == 3 || c == 7) chk($sformatf("b2b_done_c%0d", c), {done, stall}, 2'b10);
                if (c == 4) chk("b2b_idle_stall", {stall, mem_en}, 2'b10);
                next_cycle();
            end
            mem_valid = 1'b0;
            chk("b2b_mem_en_count", n_en, 2);
            chk("b2b_rdata", rdata, 16'h2222);
            m_rdata = 16'h2222;
        end

        begin : reset_mid_access
            MemEnable = 1'b1;
            MemWrite  = 1'b0;
            addr      = 16'h0060;
            for (int c = 0; c < 6; c++) begin
                rst       = (c == 3);
                MemEnable = (c < 4);
                mem_valid = (c == 4);
                mem_rdata = 16'hFFFF;
                @(negedge clk);
                if (c == 2) chk("rstmid_wait_stall", stall, 1);
                if (c >= 4) begin
                    chk($sformatf("rstmid_c%0d_done", c), done, 0);
                    chk($sformatf("rstmid_c%0d_stall", c), stall, 0);
                    chk($sformatf("rstmid_c%0d_rdata", c), rdata, 0);
                    chk($sformatf("rstmid_c%0d_mem_en", c), mem_en, 0);
                end
                next_cycle();
            end
            mem_valid = 1'b0;
            m_rdata = '0;
        end

        for (int n = 0; n < 30; n++) begin
            logic        we  = 1'($urandom);
            logic [15:0] a   = 16'($urandom);
            logic [15:0] wd  = 16'($urandom);
            logic [15:0] rd  = 16'($urandom);
            int          k   = $urandom_range(0, 10);
            bit          mis = ALIGN && a[0];
            bit          ok  = (k >= 1) && (k <= T);
            int          st;
            logic        er;
            st = mis ? 1 : (ok ? k + 2 : T + 2);
            er = mis || !ok;
            if (!mis && ok && !we) m_rdata = rd;
            run_access(we, a, wd, k, rd, st, er, m_rdata, mis);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
